// File: rtl/matrix_stream_loader.sv
// Scatters a valid/ready scalar stream into an RW x CW register file as one-hot writes.
// Optional column-major fill is enabled with MATRIX_STREAM_LOADER_TRANSPOSE_EN.
module matrix_stream_loader #(
    parameter int unsigned DW = 16,
    parameter int unsigned RW = 4,
    parameter int unsigned CW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef MATRIX_STREAM_LOADER_TRANSPOSE_EN
    input  logic             transpose,
`endif
    input  logic             s_valid,
    input  logic [DW-1:0]    s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic [RW*CW-1:0] wren,
    output logic [DW-1:0]    wr_data,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned NW = RW * CW;
    localparam int unsigned RB = (RW > 1) ? $clog2(RW) : 1;
    localparam int unsigned CB = (CW > 1) ? $clog2(CW) : 1;
    localparam logic [RB-1:0] ROW_MAX = RB'(RW - 1);
    localparam logic [CB-1:0] COL_MAX = CB'(CW - 1);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t         state_q, state_d;
    logic [RB-1:0]  row_q, row_d;
    logic [CB-1:0]  col_q, col_d;
    logic [NW-1:0]  wren_q, wren_d;
    logic [DW-1:0]  wr_data_q, wr_data_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
`ifdef MATRIX_STREAM_LOADER_TRANSPOSE_EN
    logic           tr_q, tr_d;
`endif

    logic           final_elem;
    logic [31:0]    wr_idx;

    assign final_elem = (row_q == ROW_MAX) && (col_q == COL_MAX);
    assign wr_idx     = 32'(row_q) * 32'(CW) + 32'(col_q);

    // Next-state: one element accepted per cycle while in LOAD.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        wren_d    = '0;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
`ifdef MATRIX_STREAM_LOADER_TRANSPOSE_EN
        tr_d      = tr_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    row_d   = '0;
                    col_d   = '0;
`ifdef MATRIX_STREAM_LOADER_TRANSPOSE_EN
                    tr_d    = transpose;
`endif
                end
            end
            LOAD: begin
                if (s_valid) begin
                    wren_d    = NW'(1) << wr_idx;
                    wr_data_d = s_data;
                    done_d    = final_elem;
                    // Framing error when s_last disagrees with the element position.
                    err_d     = final_elem ^ s_last;
                    if (final_elem || s_last) begin
                        state_d = IDLE;
                    end else
`ifdef MATRIX_STREAM_LOADER_TRANSPOSE_EN
                    if (tr_q) begin
                        if (row_q == ROW_MAX) begin
                            row_d = '0;
                            col_d = col_q + CB'(1);
                        end else begin
                            row_d = row_q + RB'(1);
                        end
                    end else
`endif
                    begin
                        if (col_q == COL_MAX) begin
                            col_d = '0;
                            row_d = row_q + RB'(1);
                        end else begin
                            col_d = col_q + CB'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            wren_q    <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef MATRIX_STREAM_LOADER_TRANSPOSE_EN
            tr_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            wren_q    <= wren_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef MATRIX_STREAM_LOADER_TRANSPOSE_EN
            tr_q      <= tr_d;
`endif
        end
    end

    assign s_ready = (state_q == LOAD);
    assign busy    = (state_q == LOAD);
    assign wren    = wren_q;
    assign wr_data = wr_data_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Scoreboard bench for matrix_stream_loader: random loads against a fill-order model.
module tb_matrix_stream_loader;

    localparam int unsigned DW = 16;
    localparam int unsigned RW = 2;
    localparam int unsigned CW = 3;
    localparam int unsigned NW = RW * CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [NW-1:0] wren;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          err;
`ifdef MATRIX_STREAM_LOADER_TRANSPOSE_EN
    logic          transpose = 1'b0;
`endif

    matrix_stream_loader #(.DW(DW), .RW(RW), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef MATRIX_STREAM_LOADER_TRANSPOSE_EN
        .transpose (transpose),
`endif
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .wren      (wren),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NW-1:0] wren;
        logic [DW-1:0] data;
        logic          done;
        logic          err;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   m_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: element k of a load lands at [r][c] given by the fill order.
    function automatic int elem_index(input int k, input bit tr);
        if (tr) return (k % RW) * CW + (k / RW);
        return k;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_wren"}, 64'(wren), 64'(0));
        chk({tag, "_wr_data"}, 64'(wr_data), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_err"}, 64'(err), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_s_ready"}, 64'(s_ready), 64'(0));
    endtask

    task automatic do_reset_mid;
        rst = 1'b1;
        start = 1'b0;
        s_valid = 1'b0;
        m_busy = 1'b0;
        while (q.size() > 0 && q[$].cyc >= cyc) void'(q.pop_back());
        #1;
        check_zero_outputs("midreset");
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic do_load(input bit tr, input int early, input bit miss,
                           input int gmin, input int gmax, input int rst_after);
        int  k;
        bit  fin, last, tr_eff;
        exp_t e;
`ifdef MATRIX_STREAM_LOADER_TRANSPOSE_EN
        tr_eff = tr;
        transpose = tr;
`else
        tr_eff = 1'b0;
`endif
        start = 1'b1;
        s_valid = 1'($urandom % 2);
        s_data = DW'($urandom);
        s_last = 1'($urandom % 2);
        tick;
        start = 1'b0;
        m_busy = 1'b1;
`ifdef MATRIX_STREAM_LOADER_TRANSPOSE_EN
        transpose = 1'($urandom % 2);
`endif
        k = 0;
        while (m_busy && k < NW) begin
            repeat ($urandom_range(gmax, gmin)) begin
                s_valid = 1'b0;
                s_data = DW'($urandom);
                s_last = 1'($urandom % 2);
                start = ($urandom % 4) == 0;
                tick;
            end
            fin = (k == NW - 1);
            last = fin ? !miss : (k == early);
            s_valid = 1'b1;
            s_data = DW'($urandom);
            s_last = last;
            start = ($urandom % 4) == 0;
            e.wren = NW'(1) << elem_index(k, tr_eff);
            e.data = s_data;
            e.done = fin;
            e.err = fin ^ last;
            e.cyc = cyc + 1;
            q.push_back(e);
            tick;
            k++;
            if (fin || last) m_busy = 1'b0;
            if (m_busy && k == rst_after) do_reset_mid();
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        start = 1'b0;
    endtask

    task automatic idle_noise(input int n);
        repeat (n) begin
            s_valid = 1'($urandom % 2);
            s_data = DW'($urandom);
            s_last = 1'($urandom % 2);
            start = 1'b0;
            tick;
        end
        s_valid = 1'b0;
    endtask

    // Monitor: state flags every cycle, and every write/pulse against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("busy", 64'(busy), 64'(m_busy));
            chk("s_ready", 64'(s_ready), 64'(m_busy));
            if (wren != '0 || done || err) begin
                if (q.size() == 0) begin
                    chk("unexpected_write", 64'(wren), 64'(0));
                end else begin
                    e = q.pop_front();
                    chk("wren", 64'(wren), 64'(e.wren));
                    chk("wr_data", 64'(wr_data), 64'(e.data));
                    chk("done", 64'(done), 64'(e.done));
                    chk("err", 64'(err), 64'(e.err));
                    chk("latency_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check_zero_outputs("reset");
        tick;
        tick;
        rst = 1'b0;
        tick;
        do_load(1'b0, -1, 1'b0, 0, 0, -1);
        idle_noise(3);
        do_load(1'b0, -1, 1'b0, 2, 2, -1);
        idle_noise(2);
        do_load(1'b0, 1, 1'b0, 0, 1, -1);
        do_load(1'b0, -1, 1'b0, 0, 0, -1);
        idle_noise(2);
        do_load(1'b0, -1, 1'b1, 0, 1, -1);
        idle_noise(2);
        do_load(1'b0, -1, 1'b0, 0, 0, 2);
        idle_noise(1);
        do_load(1'b0, -1, 1'b0, 0, 0, -1);
`ifdef MATRIX_STREAM_LOADER_TRANSPOSE_EN
        idle_noise(2);
        do_load(1'b1, -1, 1'b0, 0, 0, -1);
        do_load(1'b1, 2, 1'b0, 0, 2, -1);
`endif
        for (int i = 0; i < 40; i++) begin
            idle_noise($urandom_range(3, 0));
            do_load(1'($urandom % 2),
                    (($urandom % 3) == 0) ? int'($urandom_range(NW - 2, 0)) : -1,
                    ($urandom % 4) == 0,
                    0, int'($urandom_range(2, 0)),
                    (($urandom % 8) == 0) ? int'($urandom_range(NW - 1, 1)) : -1);
        end
        idle_noise(4);
        chk("scoreboard_drained", 64'(q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_stream_loader.md
Name: matrix_stream_loader

Overview:
- Upstream feeder for the matrix register file.
- Accepts a scalar element stream on a valid/ready handshake and scatters it into the RW x CW matrix, one element per cycle, in row-major order.
- Generates the per-element write enables and the write data bus, then signals completion so downstream compute can consume `rd_data`.

Parameters:
- DW, 16: element data width in bits.
- RW, 4: matrix row count (must be >= 1).
- CW, 4: matrix column count (must be >= 1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a matrix load.
- s_valid  in  1  stream element valid.
- s_data  in  DW  stream element.
- s_last  in  1  marks the final element of a matrix.
- s_ready  out  1  loader accepts the element this cycle.
- wren  out  RW*CW  one-hot write enable; bit r*CW+c maps to element [r][c]. The top level unpacks it onto the regfile `wren[r][c]`.
- wr_data  out  DW  write data, broadcast to every `wr_data[r][c]` of the regfile.
- busy  out  1  high while in LOAD.
- done  out  1  one-cycle pulse when a load completes.
- err  out  1  one-cycle pulse on an `s_last` framing mismatch.

Behaviour:
- Reset is asynchronous, active-high; clock is `clk` only.
- Reset values: state=IDLE, row=0, col=0, `wren`=0, `wr_data`=0, `s_ready`=0, `busy`=0, `done`=0, `err`=0.
- States: IDLE, LOAD.
  - IDLE: `start`=1 -> LOAD with row=0, col=0. `s_valid` is ignored in IDLE and no element is consumed.
  - LOAD: `s_ready`=1 combinationally; an element is accepted when `s_valid` and `s_ready` are both high.
- Counter widths are max(1,$clog2(RW)) and max(1,$clog2(CW)).
- Accept at cycle N:
  - At cycle N+1, `wren` bit (row*CW+col) is 1 for exactly one cycle and `wr_data`=`s_data`.
  - Latency from accept to write enable is 1 cycle; throughput is 1 element per cycle.
  - `wren` is all zeros on every cycle with no write.
- Index advance on accept:
  - col wraps CW-1 -> 0 and increments row.
  - On the final element (row=RW-1, col=CW-1), return to IDLE.
- `done` pulses in the same cycle as the final `wren`, i.e. cycle N+1 of the final accept.
- `busy`=1 exactly while the state is LOAD.
- Framing:
  - `s_last`=1 on a non-final element: that element is still written, `err` pulses with its `wren`, the state returns to IDLE, and `done` is not asserted.
  - `s_last`=0 on the final element: the element is written, and `done` and `err` both pulse.
- `start` asserted while in LOAD is ignored; no restart.
- `start` and `s_valid` in the same cycle in IDLE: the transition occurs, and the element is not consumed that cycle.
- `rst` asserted mid-load: immediate return to IDLE and all outputs go to zero. A write registered before reset is lost if reset lands in its output cycle. Partial matrix contents in the regfile are left as-is.
- RW=CW=1: the first accept is the final element; it produces a single write plus `done`.

Optional Feature:
- Macro: MATRIX_STREAM_LOADER_TRANSPOSE_EN.
- When defined:
  - Add input port `transpose` (1 bit), sampled on the `start` accept and held for the whole load.
  - `transpose`=1 fills column-major: row increments first, wraps RW-1 -> 0, then col increments.
  - The final element is still [RW-1][CW-1].
  - The `wren` bit mapping r*CW+c is unchanged.
- When undefined: no `transpose` port; row-major only.

Test Plan:
- Reset then RW=CW=2 row-major. Stream 0xA,0xB,0xC,0xD back-to-back with `s_last` on 0xD -> `wren` bits 0,1,2,3 on consecutive cycles carrying those values; `done`=1 with bit 3; `busy` falls next cycle.
- Same load with `s_valid` gaps of 2 cycles between elements -> `wren` asserts only one cycle after each accept and is 0 in the gaps; the 4 writes are unchanged.
- Early `s_last` on 2nd element (0xB) -> bits 0,1 written; `err` pulses with bit 1; no `done`; back to IDLE; a following `start` restarts at [0][0].
- `s_last` missing on 4th element -> bit 3 written; `done` and `err` both pulse that cycle.
- Assert `rst` after 2 accepts -> outputs 0 asynchronously; `s_ready`=0; a later `start` with 4 elements writes bits 0..3 correctly.
- TRANSPOSE_EN defined, `transpose`=1, RW=2 CW=3, stream 1..6 -> `wren` bit order 0,3,1,4,2,5 with data 1..6; `done` with bit 5.
